// File: rtl/hilo_write_arbiter_pkg.sv
// Shared constants and the grant-selection helper for the HI/LO write arbiter.
package hilo_write_arbiter_pkg;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   // Round-robin choice: a lone requester wins, a tie goes opposite to last_grant.
   function automatic logic [1:0] pick_grant(input logic a_valid,
                                             input logic b_valid,
                                             input logic last_grant);
      logic [1:0] grant;
      grant = 2'b00;
      if (a_valid && b_valid) begin
         if (last_grant == SEL_A) grant = 2'b10;
         else                     grant = 2'b01;
      end else begin
         grant = {b_valid, a_valid};
      end
      return grant;
   endfunction

endpackage

// File: rtl/hilo_write_arbiter_mux.sv
// Data-path 2:1 mux feeding the HI/LO output register.
module Mux64Bit2To1 #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? inB : inA;

endmodule

// File: rtl/hilo_write_arbiter.sv
// Round-robin arbiter between multiplier (A) and divider (B) results, with a
// one-entry output register in front of the HI/LO write port.
module hilo_write_arbiter
   import hilo_write_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  a_valid,
   input  logic [DATA_WIDTH-1:0] a_data,
   output logic                  a_ready,
   input  logic                  b_valid,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  b_ready,
   output logic                  sel,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_src,
   input  logic                  out_ready
);

   // Handshake: a transfer happens on any rising edge where valid and ready are
   // both high; ready never depends on data, only on valids, out_ready and state.

   out_state_e            state, state_next;
   logic                  last_grant, last_grant_next;
   logic [1:0]            grant;
   logic                  can_accept;
   logic                  accept;
   logic [DATA_WIDTH-1:0] mux_out;

   Mux64Bit2To1 #(
      .WIDTH (DATA_WIDTH)
   ) u_mux (
      .inA (a_data),
      .inB (b_data),
      .sel (sel),
      .y   (mux_out)
   );

   assign grant      = pick_grant(a_valid, b_valid, last_grant);
   assign can_accept = (state == ST_EMPTY) || out_ready;
   assign a_ready    = !Rst && can_accept && grant[0];
   assign b_ready    = !Rst && can_accept && grant[1];
   assign accept     = a_ready || b_ready;
   assign out_valid  = (state == ST_FULL);

   // With no grant, sel parks on last_grant so the mux does not toggle.
   assign sel = grant[1] ? SEL_B : (grant[0] ? SEL_A : last_grant);

   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      if (accept) begin
         state_next      = ST_FULL;
         last_grant_next = sel;
      end else if ((state == ST_FULL) && out_ready) begin
         state_next = ST_EMPTY;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= ST_EMPTY;
         last_grant <= SEL_B;
         out_data   <= '0;
         out_src    <= SEL_A;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         if (accept) begin
            out_data <= mux_out;
            out_src  <= sel;
         end
      end
   end

endmodule

// File: tb/tb_hilo_write_arbiter.sv
// Directed bench for hilo_write_arbiter: a cycle-level result model checked on
// every falling edge, plus literal expectations from the scenarios below.
module tb_hilo_write_arbiter;

   localparam int W = 64;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         a_valid, b_valid, out_ready;
   logic [W-1:0] a_data, b_data;
   logic         a_ready, b_ready, sel, out_valid, out_src;
   logic [W-1:0] out_data;

   int checks   = 0;
   int failures = 0;

   // Model of the output register: what HI/LO should be seeing.
   logic         m_init  = 1'b0;
   logic         m_valid = 1'b0;
   logic [W-1:0] m_data  = '0;
   logic         m_src   = 1'b0;
   logic         m_last  = 1'b1;

   logic         src_log[$];
   logic         cap_src = 1'b0;

   hilo_write_arbiter #(.DATA_WIDTH(W)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // -1 = nobody, 0 = A, 1 = B.
   function automatic int winner(input logic av, input logic bv, input logic last);
      if (av && bv) return (last == 1'b0) ? 1 : 0;
      if (av) return 0;
      if (bv) return 1;
      return -1;
   endfunction

   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   // Model update at the active edge, from the same inputs the DUT samples.
   always @(posedge Clk) begin
      int  w;
      logic room;
      if (Rst) begin
         m_init  = 1'b1;
         m_valid = 1'b0;
         m_data  = '0;
         m_src   = 1'b0;
         m_last  = 1'b1;
      end else if (m_init) begin
         w    = winner(a_valid, b_valid, m_last);
         room = !m_valid || out_ready;
         if (room && w >= 0) begin
            m_data  = (w == 1) ? b_data : a_data;
            m_src   = (w == 1);
            m_last  = (w == 1);
            m_valid = 1'b1;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Compare process: every falling edge once reset has been seen.
   always @(negedge Clk) begin
      int  w;
      logic room;
      if (m_init) begin
         w    = winner(a_valid, b_valid, m_last);
         room = !m_valid || out_ready;
         chk("a_ready", W'(a_ready), W'(!Rst && room && w == 0));
         chk("b_ready", W'(b_ready), W'(!Rst && room && w == 1));
         chk("out_valid", W'(out_valid), W'(m_valid));
         chk("out_data", out_data, m_data);
         chk("out_src", W'(out_src), W'(m_src));
         if (w >= 0) chk("sel", W'(sel), W'(w == 1));
         if (cap_src) src_log.push_back(out_src);
      end
   end

   initial begin
      // Reset with both requesters already valid.
      Rst       = 1'b1;
      a_valid   = 1'b1;
      b_valid   = 1'b1;
      a_data    = 64'hA000_0000_0000_0001;
      b_data    = 64'hB000_0000_0000_0001;
      out_ready = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      chk("rst_a_ready", W'(a_ready), W'(0));
      chk("rst_b_ready", W'(b_ready), W'(0));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_out_data", out_data, 64'h0);
      next_cycle();
      Rst = 1'b0;
      @(negedge Clk);
      chk("first_a_ready", W'(a_ready), W'(1));
      chk("first_b_ready", W'(b_ready), W'(0));
      next_cycle();
      a_valid = 1'b0;
      b_valid = 1'b0;
      @(negedge Clk);
      chk("first_out_data", out_data, 64'hA000_0000_0000_0001);
      chk("first_out_src", W'(out_src), W'(0));

      // Single source A.
      next_cycle();
      a_valid = 1'b1;
      a_data  = 64'h0000_0001_0000_0002;
      @(negedge Clk);
      chk("single_a_ready", W'(a_ready), W'(1));
      next_cycle();
      a_valid = 1'b0;
      // Drain-and-refill: FULL with out_ready, B arrives.
      b_valid = 1'b1;
      b_data  = 64'hB0B0_0000_1111_2222;
      @(negedge Clk);
      chk("single_out_data", out_data, 64'h0000_0001_0000_0002);
      chk("single_out_src", W'(out_src), W'(0));
      chk("refill_b_ready", W'(b_ready), W'(1));
      next_cycle();
      b_valid = 1'b0;
      @(negedge Clk);
      chk("refill_out_valid", W'(out_valid), W'(1));
      chk("refill_out_data", out_data, 64'hB0B0_0000_1111_2222);

      // Contention for 4 cycles; last grant was B so A leads.
      next_cycle();
      a_valid = 1'b1;
      b_valid = 1'b1;
      a_data  = 64'hAAAA_AAAA_AAAA_AAAA;
      b_data  = 64'hBBBB_BBBB_BBBB_BBBB;
      repeat (4) next_cycle();
      cap_src = 1'b1;
      // Backpressure: output held, both still requesting.
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         chk("bp_a_ready", W'(a_ready), W'(0));
         chk("bp_b_ready", W'(b_ready), W'(0));
         chk("bp_out_data", out_data, 64'hBBBB_BBBB_BBBB_BBBB);
         next_cycle();
      end
      cap_src = 1'b0;
      out_ready = 1'b1;
      @(negedge Clk);
      chk("bp_release_a_ready", W'(a_ready), W'(1));
      chk("bp_release_b_ready", W'(b_ready), W'(0));
      next_cycle();
      a_valid = 1'b0;
      b_valid = 1'b0;

      // Reset mid-transfer; last grant before reset is A.
      a_valid   = 1'b1;
      a_data    = 64'hDEAD_BEEF_0000_0000;
      b_valid   = 1'b0;
      @(negedge Clk);
      next_cycle();
      a_valid   = 1'b0;
      out_ready = 1'b0;
      @(negedge Clk);
      chk("mid_full_data", out_data, 64'hDEAD_BEEF_0000_0000);
      next_cycle();
      Rst = 1'b1;
      next_cycle();
      Rst       = 1'b0;
      a_valid   = 1'b1;
      b_valid   = 1'b1;
      a_data    = 64'hA5A5_0000_0000_0001;
      b_data    = 64'hB5B5_0000_0000_0001;
      out_ready = 1'b1;
      @(negedge Clk);
      chk("mid_rst_out_valid", W'(out_valid), W'(0));
      chk("mid_rst_out_data", out_data, 64'h0);
      chk("mid_rst_tie_a", W'(a_ready), W'(1));
      next_cycle();
      a_valid = 1'b0;
      b_valid = 1'b0;
      repeat (3) next_cycle();

      // Contention sources: the four grants seen one cycle later as out_src,
      // captured at the first backpressure cycle (the last grant, B) ...
      // Build the full sequence from the first capture cycle backwards is not
      // possible, so the contention window is re-run with capture on.
      src_log.delete();
      a_valid = 1'b1;
      b_valid = 1'b1;
      next_cycle();
      cap_src = 1'b1;
      repeat (4) next_cycle();
      cap_src = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      chk("cont_len", W'(src_log.size()), W'(4));
      if (src_log.size() == 4) begin
         // Last grant before this window was A (post-reset accept), so B leads here.
         chk("cont_src0", W'(src_log[0]), W'(1));
         chk("cont_src1", W'(src_log[1]), W'(0));
         chk("cont_src2", W'(src_log[2]), W'(1));
         chk("cont_src3", W'(src_log[3]), W'(0));
      end
      repeat (2) next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
